// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants for the display scan controller: grant encodings, digit count, default timing.
// No logic; imported by disp_scan_ctrl and scan_timer.
// No flow control.
package disp_scan_ctrl_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_SRC0 = 2'b01;
  localparam logic [1:0] GNT_SRC1 = 2'b10;

  localparam int DIGITS = 4;

  localparam int DEF_SCAN_PERIOD  = 50000;
  localparam int DEF_HOLD_FRAMES  = 8;
  localparam int DEF_BLINK_FRAMES = 64;

endpackage

// File: rtl/scan_timer.sv
// Digit-slot prescaler and 2-bit scan counter; flags the last cycle of each slot and of each frame.
// Latency: scanning advances one edge after scan_tick; ticks are combinational from registers.
// No backpressure: free-running.
module scan_timer
  import disp_scan_ctrl_pkg::*;
#(
  parameter int SCAN_PERIOD = DEF_SCAN_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] scanning,
  output logic       scan_tick,
  output logic       frame_tick
);

  localparam int PW = $clog2(SCAN_PERIOD);

  logic [PW-1:0] prescaler;

  assign scan_tick  = (prescaler == PW'(SCAN_PERIOD - 1));
  assign frame_tick = scan_tick && (scanning == 2'(DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      scanning  <= '0;
    end else if (scan_tick) begin
      prescaler <= '0;
      scanning  <= scanning + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan sequencer plus frame-aligned round-robin arbiter between two display sources, with per-digit blink.
// Latency: gnt/disp_num update only on the edge ending a frame (4*SCAN_PERIOD cycles); blank is combinational.
// No backpressure: requests are level-sampled at frame boundaries, short pulses between boundaries are dropped.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int SCAN_PERIOD  = DEF_SCAN_PERIOD,
  parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] num0,
  input  logic [31:0] num1,
  input  logic [3:0]  blink_mask,
  output logic [1:0]  gnt,
  output logic [31:0] disp_num,
  output logic [1:0]  scanning,
  output logic        frame_tick,
  output logic        blank
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          scan_tick;
  logic [1:0]    next_gnt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_inc;
  logic          hold_ok;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  scan_timer #(
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_scan_timer (
    .clk        (clk),
    .reset      (reset),
    .scanning   (scanning),
    .scan_tick  (scan_tick),
    .frame_tick (frame_tick)
  );

  // The frame ending now counts toward the hold, so an owner gets exactly HOLD_FRAMES full frames.
  assign hold_inc = (hold_cnt == HW'(HOLD_FRAMES)) ? hold_cnt : hold_cnt + HW'(1);
  assign hold_ok  = (hold_inc == HW'(HOLD_FRAMES));

  always_comb begin
    next_gnt = GNT_NONE;
    case (gnt)
      GNT_SRC0: begin
        if (req[0] && (!req[1] || !hold_ok)) next_gnt = GNT_SRC0;
        else if (req[1])                     next_gnt = GNT_SRC1;
        else                                 next_gnt = GNT_NONE;
      end
      GNT_SRC1: begin
        if (req[1] && (!req[0] || !hold_ok)) next_gnt = GNT_SRC1;
        else if (req[0])                     next_gnt = GNT_SRC0;
        else                                 next_gnt = GNT_NONE;
      end
      default: begin
        if (req[0])      next_gnt = GNT_SRC0;
        else if (req[1]) next_gnt = GNT_SRC1;
        else             next_gnt = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= GNT_NONE;
      disp_num <= '0;
      hold_cnt <= '0;
    end else if (frame_tick) begin
      gnt      <= next_gnt;
      hold_cnt <= (next_gnt != gnt) ? '0 : hold_inc;
      case (next_gnt)
        GNT_SRC0: disp_num <= num0;
        GNT_SRC1: disp_num <= num1;
        default:  disp_num <= disp_num;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // blink_mask is treated as quasi-static configuration.
  assign blank = blink_phase && blink_mask[scanning];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SCAN_PERIOD=4, HOLD_FRAMES=2, BLINK_FRAMES=2 (16-cycle frames).
// Cycle c = c-th rising edge after reset release; outputs sampled 1 time unit after that edge.
module tb_disp_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] num0;
  logic [31:0] num1;
  logic [3:0]  blink_mask;
  logic [1:0]  gnt;
  logic [31:0] disp_num;
  logic [1:0]  scanning;
  logic        frame_tick;
  logic        blank;

  int n_vec;
  int n_err;
  int cyc;

  disp_scan_ctrl #(
    .SCAN_PERIOD  (4),
    .HOLD_FRAMES  (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .num0       (num0),
    .num1       (num1),
    .blink_mask (blink_mask),
    .gnt        (gnt),
    .disp_num   (disp_num),
    .scanning   (scanning),
    .frame_tick (frame_tick),
    .blank      (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [1:0]  exp_gnt;
  logic [31:0] exp_num;
  logic        phase;

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    reset = 1'b1;
    req = 2'b00;
    num0 = 32'h0;
    num1 = 32'h0;
    blink_mask = 4'b1111;
    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_num", disp_num, 32'h0);
    chk("rst_scan", 32'(scanning), 32'h0);
    chk("rst_ftick", 32'(frame_tick), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);

    // 1: idle scan
    do_reset();
    for (int c = 0; c < 40; c++) begin
      chk("t1_scan", 32'(scanning), 32'((c / 4) % 4));
      chk("t1_ftick", 32'(frame_tick), 32'(c % 16 == 15));
      chk("t1_gnt", 32'(gnt), 32'h0);
      chk("t1_num", disp_num, 32'h0);
      step();
    end

    // 2: single source, snapshot only at frame edges
    num0 = 32'h1234_5678;
    num1 = 32'h5555_5555;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (c == 2)  req = 2'b01;
      if (c == 20) num0 = 32'hAAAA_0000;
      exp_gnt = (c < 16) ? 2'b00 : 2'b01;
      exp_num = (c < 16) ? 32'h0 : (c < 32) ? 32'h1234_5678 : 32'hAAAA_0000;
      chk("t2_gnt", 32'(gnt), 32'(exp_gnt));
      chk("t2_num", disp_num, exp_num);
      step();
    end

    // 3: both requesting, round-robin after two held frames
    req = 2'b11;
    num0 = 32'h0000_0A0A;
    num1 = 32'h0000_0B0B;
    do_reset();
    for (int c = 0; c < 96; c++) begin
      exp_gnt = (c < 16) ? 2'b00 : (c < 48) ? 2'b01 : (c < 80) ? 2'b10 : 2'b01;
      exp_num = (exp_gnt == 2'b00) ? 32'h0 : (exp_gnt == 2'b01) ? 32'h0000_0A0A : 32'h0000_0B0B;
      chk("t3_gnt", 32'(gnt), 32'(exp_gnt));
      chk("t3_num", disp_num, exp_num);
      step();
    end

    // 4: owner drops request, hold waived; then release to none
    req = 2'b01;
    num0 = 32'hC0C0_C0C0;
    num1 = 32'hD1D1_D1D1;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if (c == 20) req = 2'b10;
      if (c == 36) req = 2'b00;
      exp_gnt = (c < 16) ? 2'b00 : (c < 32) ? 2'b01 : (c < 48) ? 2'b10 : 2'b00;
      exp_num = (c < 16) ? 32'h0 : (c < 32) ? 32'hC0C0_C0C0 : 32'hD1D1_D1D1;
      chk("t4_gnt", 32'(gnt), 32'(exp_gnt));
      chk("t4_num", disp_num, exp_num);
      step();
    end

    // 5: blink on digits 0 and 2
    req = 2'b00;
    blink_mask = 4'b0101;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      phase = ((c / 32) % 2) == 1;
      chk("t5_blank", 32'(blank), 32'(phase && blink_mask[(c / 4) % 4]));
      step();
    end

    // 6: asynchronous reset mid-frame
    req = 2'b01;
    blink_mask = 4'b1111;
    do_reset();
    while (cyc < 37) step();
    chk("t6_pre_scan", 32'(scanning), 32'h1);
    chk("t6_pre_gnt", 32'(gnt), 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_num", disp_num, 32'h0);
    chk("t6_scan", 32'(scanning), 32'h0);
    chk("t6_ftick", 32'(frame_tick), 32'h0);
    chk("t6_blank", 32'(blank), 32'h0);
    req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      chk("t6_ftick_rel", 32'(frame_tick), 32'(c == 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
